// File: rtl/safety_obi_reg_responder_if.sv
// Bus bundle between the safety core OBI data port and the core-local register interface.
// The responder takes the slave modport; the core/peripheral side (or a bench) takes master.
interface safety_obi_reg_responder_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                   obi_req;
   logic                   obi_gnt;
   logic [AddrWidth-1:0]   obi_addr;
   logic                   obi_we;
   logic [DataWidth/8-1:0] obi_be;
   logic [DataWidth-1:0]   obi_wdata;
   logic                   obi_rvalid;
   logic [DataWidth-1:0]   obi_rdata;
   logic                   obi_err;

   logic                   reg_valid;
   logic                   reg_write;
   logic [AddrWidth-1:0]   reg_addr;
   logic [DataWidth-1:0]   reg_wdata;
   logic [DataWidth/8-1:0] reg_wstrb;
   logic                   reg_ready;
   logic [DataWidth-1:0]   reg_rdata;
   logic                   reg_error;

   modport slave (
      input  obi_req, obi_addr, obi_we, obi_be, obi_wdata,
      output obi_gnt, obi_rvalid, obi_rdata, obi_err,
      output reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
      input  reg_ready, reg_rdata, reg_error
   );

   modport master (
      output obi_req, obi_addr, obi_we, obi_be, obi_wdata,
      input  obi_gnt, obi_rvalid, obi_rdata, obi_err,
      input  reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb,
      output reg_ready, reg_rdata, reg_error
   );
endinterface

// File: rtl/safety_obi_reg_responder.sv
// OBI responder replaying each granted request as one register-interface access, single outstanding.
// Optional access watchdog enabled by defining SAFETY_OBI_TIMEOUT_EN.
module safety_obi_reg_responder #(
   parameter int                   AddrWidth     = 32,
   parameter int                   DataWidth     = 32,
   parameter int                   TimeoutCycles = 255,
   parameter logic [DataWidth-1:0] ErrRdata      = 32'hBADCAB1E
) (
   input logic                        clk_i,
   input logic                        rst_ni,
   safety_obi_reg_responder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   gnt;
   logic                   done;
   logic                   expire;

   logic [AddrWidth-1:0]   addr_q;
   logic                   we_q;
   logic [DataWidth/8-1:0] be_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   err_q;

   // A new request can be accepted while the previous response is on the bus.
   assign gnt  = bus.obi_req && (state_q == IDLE || state_q == RESP);
   assign done = (state_q == ACCESS) && bus.reg_ready;

`ifdef SAFETY_OBI_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (gnt) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS && !bus.reg_ready) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // A ready arriving in the last allowed cycle still completes normally.
   assign expire = (state_q == ACCESS) && !bus.reg_ready && (cnt_q == CntLast);
`else
   assign expire = 1'b0;
`endif

   // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets its default first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt) state_d = ACCESS;
         ACCESS:  if (done || expire) state_d = RESP;
         RESP:    state_d = gnt ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (gnt) begin
         addr_q  <= bus.obi_addr;
         we_q    <= bus.obi_we;
         be_q    <= bus.obi_be;
         wdata_q <= bus.obi_wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (done) begin
         rdata_q <= we_q ? '0 : bus.reg_rdata;
         err_q   <= bus.reg_error;
      end else if (expire) begin
         rdata_q <= ErrRdata;
         err_q   <= 1'b1;
      end
   end

   assign bus.obi_gnt    = gnt;
   assign bus.obi_rvalid = (state_q == RESP);
   assign bus.obi_rdata  = rdata_q;
   assign bus.obi_err    = err_q;

   assign bus.reg_valid  = (state_q == ACCESS);
   assign bus.reg_write  = we_q;
   assign bus.reg_addr   = addr_q;
   assign bus.reg_wdata  = wdata_q;
   assign bus.reg_wstrb  = be_q;

endmodule

// File: tb/tb_safety_obi_reg_responder.sv
// Bench for safety_obi_reg_responder: directed scenarios plus random traffic against a word-memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_safety_obi_reg_responder;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;
   localparam logic [31:0] BASE      = 32'h0020_1000;
`ifdef SAFETY_OBI_TIMEOUT_EN
   localparam int LONG_DELAY = 3;
`else
   localparam int LONG_DELAY = 5;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   logic [31:0] model_mem  [16];
   logic [31:0] periph_mem [16];

   safety_obi_reg_responder_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

   safety_obi_reg_responder #(
      .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO), .ErrRdata(ERR_RDATA)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic idle_inputs();
      bus.obi_req   = 1'b0;
      bus.obi_addr  = '0;
      bus.obi_we    = 1'b0;
      bus.obi_be    = '0;
      bus.obi_wdata = '0;
      bus.reg_ready = 1'b0;
      bus.reg_rdata = '0;
      bus.reg_error = 1'b0;
   endtask

   // One full transaction starting from IDLE; delay = ACCESS cycles before reg_ready.
   task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input int delay,
                          input logic err_in, input bit hold_req);
      logic [31:0] exp_rdata;
      logic [3:0]  idx;
      idx = addr[5:2];
      if (we) begin
         exp_rdata = '0;
         model_mem[idx] = merge(model_mem[idx], wdata, be);
      end else begin
         exp_rdata = model_mem[idx];
      end

      bus.obi_req = 1'b1; bus.obi_addr = addr; bus.obi_we = we; bus.obi_be = be; bus.obi_wdata = wdata;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_gnt, bus.obi_rvalid, bus.reg_valid} !== 3'b100)
         $display("FAIL %s grant cycle gnt/rvalid/valid: got %b want 100", name,
                  {bus.obi_gnt, bus.obi_rvalid, bus.reg_valid});
      else pass_cnt++;
      @(posedge clk); #1;

      if (hold_req) begin
         bus.obi_addr = ~addr; bus.obi_we = ~we; bus.obi_be = ~be; bus.obi_wdata = ~wdata;
      end else begin
         bus.obi_req = 1'b0;
      end

      for (int k = 0; k <= delay; k++) begin
         if (k == delay) begin
            bus.obi_req   = 1'b0;
            bus.reg_ready = 1'b1;
            bus.reg_error = err_in;
            bus.reg_rdata = bus.reg_write ? $urandom : periph_mem[bus.reg_addr[5:2]];
         end else begin
            bus.reg_ready = 1'b0;
            bus.reg_error = 1'($urandom);
            bus.reg_rdata = $urandom;
         end
         @(negedge clk);
         total_cnt++;
         if ({bus.reg_valid, bus.reg_write, bus.obi_gnt, bus.obi_rvalid} !== {1'b1, we, 2'b00})
            $display("FAIL %s access[%0d] valid/write/gnt/rvalid: got %b want %b", name, k,
                     {bus.reg_valid, bus.reg_write, bus.obi_gnt, bus.obi_rvalid}, {1'b1, we, 2'b00});
         else pass_cnt++;
         total_cnt++;
         if ({bus.reg_addr, bus.reg_wstrb} !== {addr, be})
            $display("FAIL %s access[%0d] addr/strb: got %h/%b want %h/%b", name, k,
                     bus.reg_addr, bus.reg_wstrb, addr, be);
         else pass_cnt++;
         if (we) begin
            total_cnt++;
            if (bus.reg_wdata !== wdata)
               $display("FAIL %s access[%0d] wdata: got %h want %h", name, k, bus.reg_wdata, wdata);
            else pass_cnt++;
         end
         if (k == delay && bus.reg_write)
            periph_mem[bus.reg_addr[5:2]] = merge(periph_mem[bus.reg_addr[5:2]], bus.reg_wdata,
                                                  bus.reg_wstrb);
         @(posedge clk); #1;
      end
      bus.reg_ready = 1'b0;

      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.reg_valid, bus.obi_err, bus.obi_rdata} !== {2'b10, err_in, exp_rdata})
         $display("FAIL %s response rvalid/valid/err/rdata: got %b%b/%b/%h want 10/%b/%h", name,
                  bus.obi_rvalid, bus.reg_valid, bus.obi_err, bus.obi_rdata, err_in, exp_rdata);
      else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.reg_valid} !== 2'b00)
         $display("FAIL %s after response rvalid/valid: got %b want 00", name,
                  {bus.obi_rvalid, bus.reg_valid});
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      total_cnt++;
      if ({bus.obi_gnt, bus.obi_rvalid, bus.obi_err, bus.reg_valid, bus.reg_write} !== 5'b0 ||
          {bus.obi_rdata, bus.reg_addr, bus.reg_wdata, bus.reg_wstrb} !== '0)
         $display("FAIL reset outputs: got gnt%b rv%b err%b val%b wr%b rdata %h addr %h wdata %h strb %b want all 0",
                  bus.obi_gnt, bus.obi_rvalid, bus.obi_err, bus.reg_valid, bus.reg_write,
                  bus.obi_rdata, bus.reg_addr, bus.reg_wdata, bus.reg_wstrb);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.reg_valid, bus.obi_gnt} !== 3'b000)
         $display("FAIL reset idle: got %b want 000", {bus.obi_rvalid, bus.reg_valid, bus.obi_gnt});
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      model_mem[0]  = 32'h1234_5678;
      periph_mem[0] = 32'h1234_5678;
      run_txn("read", 1'b0, 32'h0020_1000, 4'hF, 32'h0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_write();
      run_txn("write", 1'b1, 32'h0020_2004, 4'b0011, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
      run_txn("write_readback", 1'b0, 32'h0020_2004, 4'hF, 32'h0, 1, 1'b0, 1'b0);
   endtask

   task automatic test_delayed_ready();
      run_txn("delayed", 1'b0, BASE | 32'h8, 4'hF, 32'h0, LONG_DELAY, 1'b0, 1'b1);
   endtask

   // Second request is presented during the first response and must be granted there.
   task automatic test_back_to_back(input string name, input logic err_a);
      bus.obi_req = 1'b1; bus.obi_addr = BASE | 32'h8; bus.obi_we = 1'b0; bus.obi_be = 4'hF;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_gnt, bus.obi_rvalid} !== 2'b10)
         $display("FAIL %s a grant gnt/rvalid: got %b want 10", name, {bus.obi_gnt, bus.obi_rvalid});
      else pass_cnt++;
      @(posedge clk); #1;
      bus.obi_req = 1'b0; bus.reg_ready = 1'b1; bus.reg_error = err_a;
      bus.reg_rdata = periph_mem[bus.reg_addr[5:2]];
      @(negedge clk);
      total_cnt++;
      if ({bus.reg_valid, bus.reg_addr} !== {1'b1, BASE | 32'h8})
         $display("FAIL %s a access valid/addr: got %b/%h want 1/%h", name, bus.reg_valid,
                  bus.reg_addr, BASE | 32'h8);
      else pass_cnt++;
      @(posedge clk); #1;
      bus.reg_ready = 1'b0; bus.reg_error = 1'b0;
      bus.obi_req = 1'b1; bus.obi_addr = BASE | 32'hC;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.obi_gnt, bus.obi_err, bus.obi_rdata} !== {2'b11, err_a, model_mem[2]})
         $display("FAIL %s a response rvalid/gnt/err/rdata: got %b%b/%b/%h want 11/%b/%h", name,
                  bus.obi_rvalid, bus.obi_gnt, bus.obi_err, bus.obi_rdata, err_a, model_mem[2]);
      else pass_cnt++;
      @(posedge clk); #1;
      bus.obi_req = 1'b0; bus.reg_ready = 1'b1;
      bus.reg_rdata = periph_mem[bus.reg_addr[5:2]];
      @(negedge clk);
      total_cnt++;
      if ({bus.reg_valid, bus.obi_rvalid, bus.reg_addr} !== {2'b10, BASE | 32'hC})
         $display("FAIL %s b access valid/rvalid/addr: got %b%b/%h want 10/%h", name,
                  bus.reg_valid, bus.obi_rvalid, bus.reg_addr, BASE | 32'hC);
      else pass_cnt++;
      @(posedge clk); #1;
      bus.reg_ready = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.obi_err, bus.obi_rdata} !== {2'b10, model_mem[3]})
         $display("FAIL %s b response rvalid/err/rdata: got %b/%b/%h want 1/0/%h", name,
                  bus.obi_rvalid, bus.obi_err, bus.obi_rdata, model_mem[3]);
      else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++;
      if (bus.obi_rvalid !== 1'b0)
         $display("FAIL %s trailing rvalid: got %b want 0", name, bus.obi_rvalid);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_access();
      bus.obi_req = 1'b1; bus.obi_addr = BASE | 32'h14; bus.obi_we = 1'b0; bus.obi_be = 4'hF;
      @(posedge clk); #1;
      bus.obi_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.reg_valid !== 1'b1)
         $display("FAIL reset_mid pre valid: got %b want 1", bus.reg_valid);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.reg_valid, bus.obi_rvalid} !== 2'b00)
         $display("FAIL reset_mid async valid/rvalid: got %b want 00", {bus.reg_valid, bus.obi_rvalid});
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      bus.reg_ready = 1'b1; bus.reg_rdata = $urandom;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({bus.obi_rvalid, bus.reg_valid} !== 2'b00)
            $display("FAIL reset_mid post[%0d] rvalid/valid: got %b want 00", c,
                     {bus.obi_rvalid, bus.reg_valid});
         else pass_cnt++;
      end
      @(posedge clk); #1;
      bus.reg_ready = 1'b0;
      run_txn("reset_mid_recover", 1'b0, BASE | 32'h14, 4'hF, 32'h0, 1, 1'b0, 1'b0);
   endtask

`ifdef SAFETY_OBI_TIMEOUT_EN
   task automatic test_timeout();
      bus.obi_req = 1'b1; bus.obi_addr = BASE | 32'h18; bus.obi_we = 1'b0; bus.obi_be = 4'hF;
      @(posedge clk); #1;
      bus.obi_req = 1'b0; bus.reg_ready = 1'b0;
      for (int c = 0; c < TO; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({bus.reg_valid, bus.obi_rvalid} !== 2'b10)
            $display("FAIL timeout wait[%0d] valid/rvalid: got %b want 10", c,
                     {bus.reg_valid, bus.obi_rvalid});
         else pass_cnt++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      total_cnt++;
      if ({bus.obi_rvalid, bus.reg_valid, bus.obi_err, bus.obi_rdata} !== {3'b101, ERR_RDATA})
         $display("FAIL timeout response rvalid/valid/err/rdata: got %b%b/%b/%h want 10/1/%h",
                  bus.obi_rvalid, bus.reg_valid, bus.obi_err, bus.obi_rdata, ERR_RDATA);
      else pass_cnt++;
      @(posedge clk); #1;
      run_txn("timeout_tie", 1'b0, BASE | 32'h18, 4'hF, 32'h0, TO - 1, 1'b0, 1'b0);
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [3:0] idx;
         idx = 4'($urandom_range(0, 15));
         run_txn($sformatf("random%0d", n), 1'($urandom), BASE | {26'd0, idx, 2'b00},
                 4'($urandom), $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), 1'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         model_mem[i]  = $urandom;
         periph_mem[i] = model_mem[i];
      end
      test_reset();
      test_read();
      test_write();
      test_delayed_ready();
      test_back_to_back("error_then_next", 1'b1);
      test_back_to_back("back_to_back", 1'b0);
      test_reset_mid_access();
`ifdef SAFETY_OBI_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
